// File: rtl/cto3_pkg.sv
// Shared types and defaults for the CTO3 input conditioner.
// Every file in the slice pulls these in with import cto3_pkg::*.
package cto3_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } deb_state_t;

  localparam int CTO3_WIDTH          = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/cto3_debounce_bit.sv
// One input channel: a plain flop-chain synchroniser followed by a
// STABLE/SETTLING debounce FSM with a saturating hold counter.
module cto3_debounce_bit
  import cto3_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw,
  output logic       level,
  output logic       changed,
  output logic       commit,
  output deb_state_t state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   changed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      changed_q <= commit;
    end
  end

  // The counter saturates at CNT_LAST: reaching it is the commit itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    commit  = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync != level_q) begin
          state_d = SETTLING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      SETTLING: begin
        if (sync == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          level_d = sync;
          state_d = STABLE;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level   = level_q;
  assign changed = changed_q;
  assign state   = state_q;

endmodule

// File: rtl/cto3_input_conditioner.sv
// Conditions raw pad lines into the a,b,c,d inputs of the CTO3 logic:
// per-bit sync + debounce, with one merged change strobe for all bits.
module cto3_input_conditioner
  import cto3_pkg::*;
#(
  parameter int WIDTH           = CTO3_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] abcd_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] changed_mask,
  output logic             settling
);

  logic [WIDTH-1:0] commit_vec;
  logic [WIDTH-1:0] settling_vec;
  deb_state_t       chan_state [WIDTH];
  logic             out_valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    cto3_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (raw_in[i]),
      .level  (abcd_out[i]),
      .changed(changed_mask[i]),
      .commit (commit_vec[i]),
      .state  (chan_state[i])
    );
    assign settling_vec[i] = (chan_state[i] == SETTLING);
  end

  // Registered from the same commit strobes that load abcd_out, so the
  // pulse lines up with the new vector and is one pulse for all bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= |commit_vec;
    end
  end

  assign out_valid = out_valid_q;
  assign settling  = |settling_vec;

endmodule
